// File: rtl/capture_ctrl.sv
// Acquisition sequencer: fills the pre-trigger window, arms the trigger logic,
// counts post-trigger samples and reports completion to the command layer.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_cap,
  input  logic              stop_cap,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              en_sample,
  input  logic              triggered,
  input  logic              clr_done,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Control inputs are single-cycle pulses with no ready/ack: start_cap is
  // taken only in IDLE, stop_cap in any state, and each en_sample strobe
  // produces exactly one write while capturing.

  // Encoding is visible on state_dbg: IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4.
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_P   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] pos_r;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W-1:0] pre_next;
  logic [ADDR_W:0]   post_next;
  logic [ADDR_W:0]   post_target;
  logic              capturing;

  // Post target spans 1..DEPTH so pre + post always fills the whole RAM.
  assign post_target = DEPTH_P - {1'b0, pos_r};
  assign pre_next    = pre_cnt + ONE_A;
  assign post_next   = post_cnt + ONE_P;
  assign capturing   = (state == PRE) || (state == ARMED) || (state == POST);

  assign we               = capturing && en_sample && !stop_cap;
  assign armed            = (state == ARMED) || (state == POST);
  assign busy             = (state != IDLE);
  assign set_capture_done = (state == DONE) && !stop_cap;
  assign state_dbg        = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pos_r        <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      waddr        <= '0;
      trig_addr    <= '0;
      capture_done <= 1'b0;
    end else begin
      // Set beats clear when both land in the same cycle.
      if (clr_done)         capture_done <= 1'b0;
      if (set_capture_done) capture_done <= 1'b1;

      if (stop_cap) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_cap) begin
              pos_r        <= trig_pos;
              waddr        <= '0;
              pre_cnt      <= '0;
              capture_done <= 1'b0;
              state        <= (trig_pos != '0) ? PRE : ARMED;
            end
          end
          PRE: begin
            if (we) begin
              waddr   <= waddr + ONE_A;
              pre_cnt <= pre_next;
              if (pre_next == pos_r) state <= ARMED;
            end
          end
          ARMED: begin
            if (we) waddr <= waddr + ONE_A;
            if (triggered) begin
              trig_addr <= waddr;
              post_cnt  <= we ? ONE_P : '0;
              // Only pos_r = DEPTH-1 can finish on the trigger write itself.
              state     <= (we && (post_target == ONE_P)) ? DONE : POST;
            end
          end
          POST: begin
            if (we) begin
              waddr    <= waddr + ONE_A;
              post_cnt <= post_next;
              if (post_next == post_target) state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: reset, nominal, zero pre-trigger, wrap with
// gapped strobes, abort, flag contention and mid-capture reset.
module tb_capture_ctrl;

  localparam int ADDR_W = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_cap;
  logic              stop_cap;
  logic [ADDR_W-1:0] trig_pos;
  logic              en_sample;
  logic              triggered;
  logic              clr_done;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic [2:0]        state_dbg;

  int checks = 0;
  int fails  = 0;
  int wr_cnt = 0;
  int off_strobe = 0;
  int scd_cnt = 0;
  int base;
  int scd_base;
  logic sb_on = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_cap        (start_cap),
    .stop_cap         (stop_cap),
    .trig_pos         (trig_pos),
    .en_sample        (en_sample),
    .triggered        (triggered),
    .clr_done         (clr_done),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .we               (we),
    .waddr            (waddr),
    .trig_addr        (trig_addr),
    .busy             (busy),
    .state_dbg        (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic gapped_write();
    en_sample = 1'b1;
    tick();
    en_sample = 1'b0;
    tick();
    tick();
  endtask

  // Scoreboard and counters sample on the falling edge.
  always @(negedge clk) begin
    if (we) wr_cnt++;
    if (we && !en_sample) off_strobe++;
    if (set_capture_done) scd_cnt++;
    if (sb_on && we) begin
      if (exp_q.size() == 0) chk("sb_extra_write", 32'd1, 32'd0);
      else chk("sb_waddr", 32'(waddr), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; start_cap = 1'b0; stop_cap = 1'b0; trig_pos = '0;
    en_sample = 1'b0; triggered = 1'b0; clr_done = 1'b0;
    ticks(2);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_cdone", 32'(capture_done), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: trig_pos=100, trigger 50 cycles after armed
    for (int i = 0; i < 562; i++) exp_q.push_back(ADDR_W'(i % 512));
    sb_on = 1'b1;
    base = wr_cnt; scd_base = scd_cnt;
    trig_pos = 9'd100; start_cap = 1'b1; en_sample = 1'b1;
    #1 chk("nom_idle_we", 32'(we), 32'd0);
    tick();
    // start_cap and a new trig_pos while busy must be ignored
    trig_pos = 9'd5; start_cap = 1'b1;
    #1 chk("nom_pre_state", 32'(state_dbg), 32'(S_PRE));
    tick();
    start_cap = 1'b0; trig_pos = 9'd0;
    ticks(98);
    chk("nom_pre_armed", 32'(armed), 32'd0);
    chk("nom_pre_waddr", 32'(waddr), 32'd99);
    tick();
    chk("nom_armed_rise", 32'(armed), 32'd1);
    chk("nom_armed_waddr", 32'(waddr), 32'd100);
    ticks(50);
    chk("nom_trig_waddr", 32'(waddr), 32'd150);
    triggered = 1'b1;
    #1 base = wr_cnt;
    tick();
    triggered = 1'b0;
    chk("nom_post_state", 32'(state_dbg), 32'(S_POST));
    ticks(410);
    chk("nom_post_not_done", 32'(set_capture_done), 32'd0);
    chk("nom_post_armed", 32'(armed), 32'd1);
    tick();
    clr_done = 1'b1;
    #1;
    chk("nom_done_pulse", 32'(set_capture_done), 32'd1);
    chk("nom_done_armed", 32'(armed), 32'd0);
    chk("nom_done_we", 32'(we), 32'd0);
    chk("nom_done_busy", 32'(busy), 32'd1);
    chk("nom_done_waddr", 32'(waddr), 32'd50);
    tick();
    chk("nom_post_writes", 32'(wr_cnt - base), 32'd412);
    chk("flag_set_wins", 32'(capture_done), 32'd1);
    chk("nom_trig_addr", 32'(trig_addr), 32'd150);
    chk("nom_single_pulse", 32'(scd_cnt - scd_base), 32'd1);
    chk("nom_idle_busy", 32'(busy), 32'd0);
    chk("nom_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    clr_done = 1'b0;
    chk("flag_clear", 32'(capture_done), 32'd0);
    sb_on = 1'b0;

    // Zero pre-trigger
    trig_pos = 9'd0; start_cap = 1'b1; en_sample = 1'b0;
    tick();
    start_cap = 1'b0;
    chk("zero_armed_state", 32'(state_dbg), 32'(S_ARMED));
    chk("zero_armed", 32'(armed), 32'd1);
    chk("zero_waddr", 32'(waddr), 32'd0);
    en_sample = 1'b1; triggered = 1'b1;
    #1 base = wr_cnt;
    tick();
    triggered = 1'b0;
    ticks(510);
    chk("zero_still_post", 32'(state_dbg), 32'(S_POST));
    tick();
    en_sample = 1'b0;
    chk("zero_done_pulse", 32'(set_capture_done), 32'd1);
    chk("zero_post_writes", 32'(wr_cnt - base), 32'd512);
    tick();
    chk("zero_cdone", 32'(capture_done), 32'd1);
    chk("zero_trig_addr", 32'(trig_addr), 32'd0);

    // Wrap with strobe every 3rd cycle, trig_pos=511
    trig_pos = 9'd511; start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    chk("wrap_cdone_clr", 32'(capture_done), 32'd0);
    triggered = 1'b1;
    gapped_write();
    triggered = 1'b0;
    chk("wrap_pre_ignores_trig", 32'(state_dbg), 32'(S_PRE));
    for (int i = 0; i < 510; i++) gapped_write();
    chk("wrap_armed", 32'(armed), 32'd1);
    chk("wrap_armed_waddr", 32'(waddr), 32'd511);
    for (int i = 0; i < 511; i++) gapped_write();
    chk("wrap_waddr_510", 32'(waddr), 32'd510);
    chk("wrap_still_armed", 32'(state_dbg), 32'(S_ARMED));
    en_sample = 1'b1; triggered = 1'b1;
    #1;
    base = wr_cnt;
    chk("wrap_trig_we", 32'(we), 32'd1);
    tick();
    en_sample = 1'b0; triggered = 1'b0;
    chk("wrap_direct_done", 32'(state_dbg), 32'(S_DONE));
    chk("wrap_done_pulse", 32'(set_capture_done), 32'd1);
    chk("wrap_trig_addr", 32'(trig_addr), 32'd510);
    chk("wrap_waddr_after", 32'(waddr), 32'd511);
    tick();
    chk("wrap_post_writes", 32'(wr_cnt - base), 32'd1);
    chk("wrap_cdone", 32'(capture_done), 32'd1);
    chk("no_off_strobe_we", 32'(off_strobe), 32'd0);

    // Abort from ARMED
    trig_pos = 9'd10; start_cap = 1'b1; en_sample = 1'b1;
    tick();
    start_cap = 1'b0;
    chk("abort_start_clears", 32'(capture_done), 32'd0);
    ticks(10);
    chk("abort_armed", 32'(armed), 32'd1);
    stop_cap = 1'b1;
    #1;
    scd_base = scd_cnt;
    chk("abort_no_write", 32'(we), 32'd0);
    tick();
    stop_cap = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_disarm", 32'(armed), 32'd0);
    chk("abort_waddr_hold", 32'(waddr), 32'd10);
    chk("abort_trig_addr", 32'(trig_addr), 32'd510);
    chk("abort_no_pulse", 32'(scd_cnt - scd_base), 32'd0);
    start_cap = 1'b1; stop_cap = 1'b1;
    tick();
    stop_cap = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'd0);
    trig_pos = 9'd3;
    tick();
    start_cap = 1'b0;
    chk("fresh_pre", 32'(state_dbg), 32'(S_PRE));
    chk("fresh_waddr", 32'(waddr), 32'd0);
    ticks(3);
    chk("fresh_armed_waddr", 32'(waddr), 32'd3);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    ticks(196);
    chk("midpost_state", 32'(state_dbg), 32'(S_POST));
    chk("midpost_waddr", 32'(waddr), 32'd200);

    // Reset mid-POST
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("mrst_armed", 32'(armed), 32'd0);
    chk("mrst_we", 32'(we), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cdone", 32'(capture_done), 32'd0);
    chk("mrst_waddr", 32'(waddr), 32'd0);
    chk("mrst_trig_addr", 32'(trig_addr), 32'd0);
    rst = 1'b0; trig_pos = 9'd2; start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    chk("rstart_we", 32'(we), 32'd1);
    chk("rstart_waddr", 32'(waddr), 32'd0);
    ticks(2);
    chk("rstart_armed", 32'(armed), 32'd1);
    chk("rstart_armed_waddr", 32'(waddr), 32'd2);

    // Final report
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
